// File: rtl/sound_pkg.sv
// rtl/sound_pkg.sv - shared constants, state type and helpers for the sound feeder
package sound_pkg;

  localparam int LANES = 4;

  localparam logic [1:0] CHAN_OFF    = 2'd0;
  localparam logic [1:0] CHAN_MONO   = 2'd1;
  localparam logic [1:0] CHAN_STEREO = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Drop counter never wraps; it pins at all-ones.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sound_feeder_if.sv
// rtl/sound_feeder_if.sv - sample stream handshake between producer and feeder
interface sound_feeder_if;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/sound_feeder.sv
// rtl/sound_feeder.sv - stages samples into 4-lane groups and writes them to the sound sink
module sound_feeder
  import sound_pkg::*;
(
  input  logic                 clk_sys,
  input  logic                 sound_reset_n,
  input  logic [1:0]           cfg_chan,
  input  logic                 blk_start,
  input  logic [15:0]          blk_samples,
  sound_feeder_if.slave        s_if,
  input  logic                 sound_write_ready,
  output logic                 sound_wren1,
  output logic                 sound_wren2,
  output logic                 sound_wren3,
  output logic                 sound_wren4,
  output logic [15:0]          sound_in1,
  output logic [15:0]          sound_in2,
  output logic [15:0]          sound_in3,
  output logic [15:0]          sound_in4,
  output logic                 blk_busy,
  output logic                 blk_done,
  output logic                 blk_ovr,
  output logic [15:0]          drop_cnt
);

  state_t      state;
  logic [1:0]  chan;
  logic [2:0]  stage_cnt;
  logic [15:0] remaining;
  logic [15:0] stage [LANES];
  logic [3:0]  wren;
  logic [15:0] lane  [LANES];

  logic        xfer;
  logic [2:0]  cnt_inc;
  logic [15:0] rem_dec;

  assign s_if.s_ready = (state == ST_FILL) && (stage_cnt < 3'(LANES)) && (remaining != 16'd0);
  assign xfer         = s_if.s_valid && s_if.s_ready;
  assign cnt_inc      = stage_cnt + 3'd1;
  assign rem_dec      = remaining - 16'd1;
  assign blk_busy     = (state != ST_IDLE);

  assign sound_wren1 = wren[0];
  assign sound_wren2 = wren[1];
  assign sound_wren3 = wren[2];
  assign sound_wren4 = wren[3];
  assign sound_in1   = lane[0];
  assign sound_in2   = lane[1];
  assign sound_in3   = lane[2];
  assign sound_in4   = lane[3];

  // Block FSM: accept samples, close groups, emit them when the sink has room.
  always_ff @(posedge clk_sys or negedge sound_reset_n) begin
    if (!sound_reset_n) begin
      state     <= ST_IDLE;
      chan      <= CHAN_OFF;
      stage_cnt <= 3'd0;
      remaining <= 16'd0;
      wren      <= 4'd0;
      blk_done  <= 1'b0;
      blk_ovr   <= 1'b0;
      drop_cnt  <= 16'd0;
      for (int k = 0; k < LANES; k++) begin
        stage[k] <= 16'd0;
        lane[k]  <= 16'd0;
      end
    end else begin
      wren     <= 4'd0;
      blk_done <= 1'b0;
      if (blk_start && (state != ST_IDLE)) begin
        blk_ovr <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (blk_start) begin
            chan      <= cfg_chan;
            remaining <= blk_samples;
            stage_cnt <= 3'd0;
            if (blk_samples == 16'd0) begin
              state    <= ST_DONE;
              blk_done <= 1'b1;
            end else begin
              state <= ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (xfer) begin
            remaining <= rem_dec;
            if (chan == CHAN_OFF) begin
              // Channel off: the sample is consumed but never staged.
              drop_cnt <= sat_inc(drop_cnt);
              if (rem_dec == 16'd0) begin
                state    <= ST_DONE;
                blk_done <= 1'b1;
              end
            end else begin
              stage[stage_cnt[1:0]] <= s_if.s_data;
              if ((rem_dec == 16'd0) && chan[1] && cnt_inc[0]) begin
                // Stereo block ended on a lone left sample: keep the count, drop it.
                drop_cnt <= sat_inc(drop_cnt);
                state    <= ST_WAIT;
              end else begin
                stage_cnt <= cnt_inc;
                if ((cnt_inc == 3'(LANES)) || (rem_dec == 16'd0)) begin
                  state <= ST_WAIT;
                end
              end
            end
          end else if (remaining == 16'd0) begin
            if (stage_cnt == 3'd0) begin
              state    <= ST_DONE;
              blk_done <= 1'b1;
            end else begin
              state <= ST_WAIT;
            end
          end else if (stage_cnt == 3'(LANES)) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (stage_cnt == 3'd0) begin
            state    <= ST_DONE;
            blk_done <= 1'b1;
          end else if (sound_write_ready) begin
            for (int k = 0; k < LANES; k++) begin
              if (3'(k) < stage_cnt) begin
                wren[k] <= 1'b1;
                lane[k] <= stage[k];
              end
            end
            stage_cnt <= 3'd0;
            if (remaining == 16'd0) begin
              state    <= ST_DONE;
              blk_done <= 1'b1;
            end else begin
              state <= ST_FILL;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sound_feeder.sv
// tb/tb_sound_feeder.sv - randomized and directed self-checking bench for sound_feeder
module tb_sound_feeder;
  import sound_pkg::*;

  logic        clk_sys = 1'b0;
  logic        sound_reset_n;
  logic [1:0]  cfg_chan;
  logic        blk_start;
  logic [15:0] blk_samples;
  wire         sound_write_ready;
  logic        sound_wren1, sound_wren2, sound_wren3, sound_wren4;
  logic [15:0] sound_in1, sound_in2, sound_in3, sound_in4;
  logic        blk_busy, blk_done, blk_ovr;
  logic [15:0] drop_cnt;

  sound_feeder_if sif ();

  sound_feeder dut (
    .clk_sys           (clk_sys),
    .sound_reset_n     (sound_reset_n),
    .cfg_chan          (cfg_chan),
    .blk_start         (blk_start),
    .blk_samples       (blk_samples),
    .s_if              (sif),
    .sound_write_ready (sound_write_ready),
    .sound_wren1       (sound_wren1),
    .sound_wren2       (sound_wren2),
    .sound_wren3       (sound_wren3),
    .sound_wren4       (sound_wren4),
    .sound_in1         (sound_in1),
    .sound_in2         (sound_in2),
    .sound_in3         (sound_in3),
    .sound_in4         (sound_in4),
    .blk_busy          (blk_busy),
    .blk_done          (blk_done),
    .blk_ovr           (blk_ovr),
    .drop_cnt          (drop_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] src_q [$];
  int          feed_gen = 0;
  int          valid_pct = 100;
  int          ready_pct = 100;
  bit          ready_hold = 1'b0;
  bit          ready_val = 1'b0;
  bit          r_rand = 1'b1;
  logic [1:0]  cur_mode = 2'd0;
  int          done_cnt = 0;
  int          got_sizes [$];
  logic [15:0] got_words [$];
  int          exp_sizes [$];
  logic [15:0] exp_words [$];
  int          exp_drop = 0;
  bit          exp_ovr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Sample source: offers queued samples with random gaps, advancing on each handshake.
  int rd_idx = 0;
  int seen_gen_f = 0;
  bit offer = 1'b0;
  always @(negedge clk_sys) begin
    if (feed_gen != seen_gen_f) begin
      seen_gen_f = feed_gen;
      rd_idx = 0;
    end else if (offer) begin
      rd_idx++;
    end
    if (rd_idx < src_q.size() && int'($urandom_range(99)) < valid_pct) begin
      sif.s_valid = 1'b1;
      sif.s_data  = src_q[rd_idx];
    end else begin
      sif.s_valid = 1'b0;
      sif.s_data  = 16'($urandom);
    end
    offer = sif.s_valid && sif.s_ready && sound_reset_n;
  end

  // Sink readiness: random each cycle unless a test pins it.
  always @(negedge clk_sys) r_rand = int'($urandom_range(99)) < ready_pct;
  assign sound_write_ready = ready_hold ? ready_val : r_rand;

  // Sink monitor: records every written group and counts done pulses.
  int seen_gen_m = 0;
  always @(negedge clk_sys) begin : mon
    logic [3:0]  w;
    logic [15:0] ins [4];
    int          c;
    if (feed_gen != seen_gen_m) begin
      seen_gen_m = feed_gen;
      got_sizes.delete();
      got_words.delete();
    end
    if (blk_done) done_cnt++;
    w   = {sound_wren4, sound_wren3, sound_wren2, sound_wren1};
    ins = '{sound_in1, sound_in2, sound_in3, sound_in4};
    if (w != 4'd0) begin
      c = $countones(w);
      chk("lanes_contiguous", 32'(w), 32'((1 << c) - 1));
      if (cur_mode[1]) chk("stereo_even_lanes", 32'(c % 2), 32'd0);
      if (cur_mode == CHAN_OFF) chk("off_mode_no_wren", 32'(w), 32'd0);
      got_sizes.push_back(c);
      for (int k = 0; k < c; k++) got_words.push_back(ins[k]);
    end
  end

  // Reference: block split into groups of four, stereo drops a trailing odd sample.
  task automatic model(input logic [1:0] mode, input logic [15:0] smp [$]);
    int n;
    int sz;
    n = smp.size();
    exp_sizes.delete();
    exp_words.delete();
    if (mode == CHAN_OFF) begin
      exp_drop += n;
      return;
    end
    for (int b = 0; b < n; b += 4) begin
      sz = (n - b < 4) ? n - b : 4;
      if (mode[1] && (sz % 2 == 1)) begin
        sz--;
        exp_drop++;
      end
      if (sz > 0) begin
        exp_sizes.push_back(sz);
        for (int j = 0; j < sz; j++) exp_words.push_back(smp[b + j]);
      end
    end
  endtask

  task automatic load_block(input logic [1:0] mode, input int n, input bit seq);
    logic [15:0] smp [$];
    for (int i = 0; i < n; i++) smp.push_back(seq ? 16'(i) : 16'($urandom));
    model(mode, smp);
    cur_mode = mode;
    src_q    = smp;
    feed_gen++;
  endtask

  task automatic start_block(input logic [1:0] mode, input logic [15:0] n);
    @(negedge clk_sys);
    cfg_chan    = mode;
    blk_samples = n;
    blk_start   = 1'b1;
    @(negedge clk_sys);
    blk_start   = 1'b0;
    cfg_chan    = 2'($urandom);
    blk_samples = 16'($urandom);
  endtask

  task automatic finish_block(input int base);
    int cyc;
    cyc = 0;
    while (!blk_done && cyc < 3000) begin
      @(negedge clk_sys);
      cyc++;
    end
    chk("done_seen", 32'(blk_done), 32'd1);
    repeat (3) @(negedge clk_sys);
    chk("done_pulses", 32'(done_cnt - base), 32'd1);
    chk("busy_after_block", 32'(blk_busy), 32'd0);
    chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    chk("blk_ovr", 32'(blk_ovr), 32'(exp_ovr));
    chk("group_count", 32'(got_sizes.size()), 32'(exp_sizes.size()));
    for (int i = 0; i < exp_sizes.size() && i < got_sizes.size(); i++)
      chk("group_size", 32'(got_sizes[i]), 32'(exp_sizes[i]));
    chk("word_count", 32'(got_words.size()), 32'(exp_words.size()));
    for (int i = 0; i < exp_words.size() && i < got_words.size(); i++)
      chk("lane_data", 32'(got_words[i]), 32'(exp_words[i]));
  endtask

  task automatic run_block(input logic [1:0] mode, input int n, input int vp, input int rp,
                           input bit seq, input bit restart);
    int base;
    valid_pct = vp;
    ready_pct = rp;
    load_block(mode, n, seq);
    base = done_cnt;
    start_block(mode, 16'(n));
    if (restart) begin
      @(negedge clk_sys);
      blk_start = 1'b1;
      exp_ovr   = 1'b1;
      @(negedge clk_sys);
      blk_start = 1'b0;
    end
    finish_block(base);
  endtask

  initial begin
    int base;
    int cyc;
    sound_reset_n = 1'b0;
    cfg_chan      = 2'd0;
    blk_start     = 1'b0;
    blk_samples   = 16'd0;
    repeat (3) @(negedge clk_sys);
    chk("rst_s_ready", 32'(sif.s_ready), 32'd0);
    chk("rst_busy", 32'(blk_busy), 32'd0);
    chk("rst_done", 32'(blk_done), 32'd0);
    chk("rst_ovr", 32'(blk_ovr), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_wren", 32'({sound_wren4, sound_wren3, sound_wren2, sound_wren1}), 32'd0);
    chk("rst_lanes", 32'(sound_in1 | sound_in2 | sound_in3 | sound_in4), 32'd0);
    sound_reset_n = 1'b1;

    // Randomized blocks across all channel modes, sizes and back-pressure levels.
    for (int b = 0; b < 25; b++) begin
      run_block(2'($urandom_range(3)), int'($urandom_range(13)),
                int'($urandom_range(100, 30)), int'($urandom_range(100, 20)), 1'b0, 1'b0);
    end

    // Mono 6 at full rate: groups of 4 and 2.
    run_block(CHAN_MONO, 6, 100, 100, 1'b1, 1'b0);
    // Stereo 7: groups of 4 and 2, last sample dropped.
    run_block(CHAN_STEREO, 7, 100, 100, 1'b1, 1'b0);

    // Stereo 1: no writes, done three cycles after the start pulse.
    valid_pct = 100;
    ready_pct = 100;
    load_block(CHAN_STEREO, 1, 1'b0);
    base = done_cnt;
    start_block(CHAN_STEREO, 16'd1);
    cyc = 1;
    while (!blk_done && cyc < 20) begin
      @(negedge clk_sys);
      cyc++;
    end
    chk("stereo1_done_latency", 32'(cyc), 32'd3);
    finish_block(base);

    // Mono 8 with the sink stalled for 20 cycles once the first group is full.
    ready_hold = 1'b1;
    ready_val  = 1'b0;
    load_block(CHAN_MONO, 8, 1'b1);
    base = done_cnt;
    start_block(CHAN_MONO, 16'd8);
    repeat (4) @(negedge clk_sys);
    for (int i = 0; i < 20; i++) begin
      chk("stall_quiet", 32'({sif.s_ready,
          |{sound_wren4, sound_wren3, sound_wren2, sound_wren1}}), 32'd0);
      if (i < 19) @(negedge clk_sys);
    end
    ready_val = 1'b1;
    @(negedge clk_sys);
    chk("stall_release_wren", 32'({sound_wren4, sound_wren3, sound_wren2, sound_wren1}), 32'hF);
    finish_block(base);
    ready_hold = 1'b0;

    // Channel off with a second start mid-block: all discarded, overrun flagged.
    run_block(CHAN_OFF, 5, 100, 100, 1'b0, 1'b1);

    // Reset with three samples staged, then a clean mono block of 4.
    valid_pct = 100;
    cur_mode  = CHAN_MONO;
    src_q     = '{16'h1111, 16'h2222, 16'h3333};
    feed_gen++;
    start_block(CHAN_MONO, 16'd8);
    repeat (4) @(negedge clk_sys);
    chk("pre_reset_busy", 32'(blk_busy), 32'd1);
    #2 sound_reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(blk_busy), 32'd0);
    chk("mid_rst_s_ready", 32'(sif.s_ready), 32'd0);
    chk("mid_rst_ovr", 32'(blk_ovr), 32'd0);
    chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
    chk("mid_rst_done", 32'(blk_done), 32'd0);
    chk("mid_rst_wren", 32'({sound_wren4, sound_wren3, sound_wren2, sound_wren1}), 32'd0);
    chk("mid_rst_lanes", 32'(sound_in1 | sound_in2 | sound_in3 | sound_in4), 32'd0);
    @(negedge clk_sys);
    sound_reset_n = 1'b1;
    exp_drop = 0;
    exp_ovr  = 1'b0;
    run_block(CHAN_MONO, 4, 100, 100, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
